pi_txn_queue: RTL and testbench
===============================

# pi_txn_queue

Pi-side transaction front end that sits directly upstream of the 68k bus-cycle engine. Decodes the Pi GPIO register-write protocol into complete bus commands, buffers them in a small FIFO, and hands them to the engine over a valid/ready handshake. Captures read data and bus-error status returned by the engine. Generates the Pi-visible busy indication (TXN_IN_PROGRESS).

## Interface
- DEPTH, 4: command FIFO entries; power of two, 2..16.
- PI_CLK  in  1  fast system clock (200 MHz); all logic on rising edge.
- PI_RST  in  1  asynchronous, active-high reset.
- PI_A  in  2  register select, raw GPIO; 0=DATA, 1=ADDR_LO, 2=ADDR_HI, 3=STATUS.
- PI_RD  in  1  raw Pi read strobe.
- PI_WR  in  1  raw Pi write strobe.
- PI_D_IN  in  16  Pi data bus input.
- PI_D_OUT  out  16  read data toward the Pi.
- PI_D_OE  out  1  drive enable for PI_D_OUT.
- TXN_IN_PROGRESS  out  1  Pi busy flag.
- CMD_VALID  out  1  FIFO head valid.
- CMD_READY  in  1  engine accepts head.
- CMD_ADDR  out  24  byte address.
- CMD_DATA  out  16  write data.
- CMD_RW  out  1  1=read.
- CMD_UDS_n, CMD_LDS_n  out  1 each  byte strobes.
- CMD_FC  out  3  function code.
- RSP_VALID  in  1  one-cycle pulse, one per accepted command.
- RSP_DATA  in  16  read data, valid with RSP_VALID.
- RSP_BERR  in  1  bus error flag, valid with RSP_VALID.
- BERR_SEEN  out  1  sticky bus-error flag.
- OVERFLOW  out  1  sticky dropped-command flag.

## Operation
- PI_RD and PI_WR each pass through a 2-flop synchronizer. A rising edge is detected on the synchronized signal. PI_A and PI_D_IN are sampled in the same cycle the edge is detected; the Pi holds them stable across the strobe.
- **Write to DATA:** data_reg <= PI_D_IN.
- **Write to ADDR_LO:** addr_lo <= PI_D_IN; sets addr_phase.
- **Write to ADDR_HI:** builds and enqueues one command, then clears addr_phase. Field mapping:
  - addr = {D[7:0], addr_lo}
  - size_byte = D[8]; rw = D[9]; fc = D[15:13]
  - Byte access: UDS_n = addr[0], LDS_n = !addr[0].
  - Word access: UDS_n = LDS_n = 0, and addr[0] is passed through unchanged.
- **Write to STATUS:** ignored by this block; it is owned by the control block.
- **Read edge on STATUS:** clears BERR_SEEN and OVERFLOW. A new set event in the same cycle takes priority over the clear.
- **PI_D_OE** = PI_RD && PI_A==0, combinational from the raw pins. PI_D_OUT = rd_data.
- **FIFO:** show-ahead. CMD_* always reflects the head entry. Transfer occurs when CMD_VALID && CMD_READY.
- **Full:** an enqueue while full with no simultaneous dequeue is dropped and sets OVERFLOW. Enqueue plus dequeue in the same cycle while full is accepted; count is unchanged.
- **Outstanding counter** (width log2(DEPTH)+1): increments on transfer, decrements on RSP_VALID. When both happen in the same cycle, the count is unchanged. RSP_VALID at zero outstanding is ignored.
- **On RSP_VALID:**
  - If the response belongs to a read, rd_data <= RSP_DATA. Reads are tracked by a per-outstanding rw shadow FIFO of depth DEPTH.
  - If RSP_BERR, BERR_SEEN <= 1.

## Timing
- Reset values: all outputs 0, except CMD_UDS_n=1, CMD_LDS_n=1, CMD_RW=1, CMD_FC=3'b111. FIFO and counters are empty.
- Pi strobe edge to internal action: 3 PI_CLK cycles (2 sync + 1 edge register).
- ADDR_HI edge detected in cycle N → entry written at end of N → CMD_VALID high in N+1 if the FIFO was empty.
- CMD_* is stable while CMD_VALID && !CMD_READY.
- TXN_IN_PROGRESS is registered (1-cycle latency). Its definition depends on configuration; see below.
- Reset mid-operation clears everything immediately, including in-flight commands. The engine shares PI_RST.

## Configuration
- PI_WRITE_POSTING_EN defined:
  - TXN_IN_PROGRESS = addr_phase || full || (a read is queued or outstanding).
  - Writes complete from the Pi's view once enqueued.
- PI_WRITE_POSTING_EN undefined:
  - TXN_IN_PROGRESS = addr_phase || !empty || outstanding!=0.
  - The Pi waits for every response.
  - DEPTH is still honoured, but the FIFO holds at most one entry under the protocol.

## Structure
- Shared package pi_regs_pkg holds:
  - REG_DATA/REG_ADDR_LO/REG_ADDR_HI/REG_STATUS constants.
  - ADDR_HI bit positions (SIZE=8, RW=9, FC=15:13).
  - The command record typedef (addr, data, rw, uds_n, lds_n, fc).
- One sub-module, pi_cmd_fifo: a parameterised show-ahead FIFO with full/empty, used for both the command queue and the rw shadow queue.

## Test plan
- **Write sequence:** ADDR_LO=0x1235, ADDR_HI=0x2112 (fc=1, rw=0, byte, A[23:16]=0x12), DATA=0xBEEF (sent first). Required: CMD_ADDR=0x121235, UDS_n=1, LDS_n=0, FC=1, CMD_DATA=0xBEEF; CMD_VALID 1 cycle after edge detect.
- **Word read:** ADDR_HI with rw=1, size=0. Engine returns RSP_DATA=0xA5A5. Required: PI_D_OUT=0xA5A5 with PI_RD, A=0; TXN_IN_PROGRESS falls 1 cycle after RSP_VALID.
- **Overflow:** hold CMD_READY=0 and issue DEPTH+1 commands. Required: OVERFLOW=1 and exactly DEPTH entries drain in order. Then a STATUS read clears OVERFLOW.
- **Full with simultaneous dequeue:** enqueue while full in the same cycle as a transfer. Required: accepted, OVERFLOW stays 0.
- **Bus error:** RSP_BERR=1 on a write. Required: BERR_SEEN=1 until a STATUS read edge. If a BERR arrives in the same cycle as the clear, BERR_SEEN stays 1.
- **Reset mid-transfer:** PI_RST pulses while CMD_VALID=1 with 2 outstanding. Required: all flags, counts, and CMD_VALID are 0 asynchronously.

Source files
------------

// File: rtl/pi_regs_pkg.sv
// pi_regs_pkg: Pi register map, ADDR_HI field positions and the bus command record.
package pi_regs_pkg;
  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_ADDR_LO = 2'd1;
  localparam logic [1:0] REG_ADDR_HI = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;
  localparam int HI_SIZE = 8;
  localparam int HI_RW = 9;
  localparam int HI_FC_LSB = 13;
  localparam int HI_FC_MSB = 15;
  typedef struct packed {
    logic [23:0] addr;
    logic [15:0] data;
    logic        rw;
    logic        uds_n;
    logic        lds_n;
    logic [2:0]  fc;
  } cmd_t;
  localparam cmd_t CMD_IDLE = '{addr: 24'h0, data: 16'h0, rw: 1'b1, uds_n: 1'b1, lds_n: 1'b1, fc: 3'b111};
endpackage

// File: rtl/pi_cmd_fifo.sv
// pi_cmd_fifo: show-ahead FIFO; a push while full is taken only together with a pop.
module pi_cmd_fifo #(
  parameter int W = 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_pop = pop && count != '0;
  assign do_push = push && (count != (AW+1)'(DEPTH) || do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/pi_txn_queue.sv
// pi_txn_queue: Pi register-write decode into queued 68k bus commands; PI_WRITE_POSTING_EN lets writes retire on enqueue.
module pi_txn_queue
  import pi_regs_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        PI_CLK,
  input  logic        PI_RST,
  input  logic [1:0]  PI_A,
  input  logic        PI_RD,
  input  logic        PI_WR,
  input  logic [15:0] PI_D_IN,
  output logic [15:0] PI_D_OUT,
  output logic        PI_D_OE,
  output logic        TXN_IN_PROGRESS,
  output logic        CMD_VALID,
  input  logic        CMD_READY,
  output logic [23:0] CMD_ADDR,
  output logic [15:0] CMD_DATA,
  output logic        CMD_RW,
  output logic        CMD_UDS_n,
  output logic        CMD_LDS_n,
  output logic [2:0]  CMD_FC,
  input  logic        RSP_VALID,
  input  logic [15:0] RSP_DATA,
  input  logic        RSP_BERR,
  output logic        BERR_SEEN,
  output logic        OVERFLOW
);
  localparam int AW = $clog2(DEPTH);
  logic [1:0] rd_s, wr_s;
  logic rd_q, wr_q, rd_edge, wr_edge;
  logic enq, enq_ok, xfer, dec, clr, cmd_full, addr_phase, sh_rw, busy;
  logic [15:0] data_reg, addr_lo;
  logic [AW:0] cmd_cnt, sh_cnt, ost;
  logic [0:0] sh_head;
  cmd_t new_cmd, head, cmd_out;
  always_ff @(posedge PI_CLK or posedge PI_RST)
    if (PI_RST) begin
      rd_s <= '0;
      wr_s <= '0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
    end else begin
      rd_s <= {rd_s[0], PI_RD};
      wr_s <= {wr_s[0], PI_WR};
      rd_q <= rd_s[1];
      wr_q <= wr_s[1];
    end
  assign rd_edge = rd_s[1] && !rd_q;
  assign wr_edge = wr_s[1] && !wr_q;
  assign enq = wr_edge && PI_A == REG_ADDR_HI;
  assign clr = rd_edge && PI_A == REG_STATUS;
  assign cmd_full = cmd_cnt == (AW+1)'(DEPTH);
  assign CMD_VALID = cmd_cnt != '0;
  assign xfer = CMD_VALID && CMD_READY;
  assign enq_ok = enq && (!cmd_full || xfer);
  assign dec = RSP_VALID && ost != '0;
  assign sh_rw = sh_cnt != '0 && sh_head[0];
  // Byte accesses steer the strobe from addr[0]; word accesses drive both and leave addr[0] as written.
  assign new_cmd = '{addr: {PI_D_IN[7:0], addr_lo}, data: data_reg, rw: PI_D_IN[HI_RW],
                     uds_n: PI_D_IN[HI_SIZE] && addr_lo[0], lds_n: PI_D_IN[HI_SIZE] && !addr_lo[0],
                     fc: PI_D_IN[HI_FC_MSB:HI_FC_LSB]};
  pi_cmd_fifo #(.W($bits(cmd_t)), .DEPTH(DEPTH)) u_cmd_q (
    .clk(PI_CLK), .rst(PI_RST), .push(enq), .pop(xfer), .din(new_cmd), .dout(head), .count(cmd_cnt)
  );
  pi_cmd_fifo #(.W(1), .DEPTH(DEPTH)) u_rw_q (
    .clk(PI_CLK), .rst(PI_RST), .push(xfer), .pop(dec), .din(head.rw), .dout(sh_head), .count(sh_cnt)
  );
  assign cmd_out = CMD_VALID ? head : CMD_IDLE;
  assign CMD_ADDR = cmd_out.addr;
  assign CMD_DATA = cmd_out.data;
  assign CMD_RW = cmd_out.rw;
  assign CMD_UDS_n = cmd_out.uds_n;
  assign CMD_LDS_n = cmd_out.lds_n;
  assign CMD_FC = cmd_out.fc;
  assign PI_D_OE = PI_RD && PI_A == REG_DATA;
`ifdef PI_WRITE_POSTING_EN
  logic [AW+1:0] rd_pend;
  always_ff @(posedge PI_CLK or posedge PI_RST)
    if (PI_RST) rd_pend <= '0;
    else rd_pend <= rd_pend + (AW+2)'(enq_ok && new_cmd.rw) - (AW+2)'(dec && sh_rw);
  assign busy = addr_phase || cmd_full || rd_pend != '0;
`else
  logic unused_enq_ok;
  assign unused_enq_ok = enq_ok;
  assign busy = addr_phase || CMD_VALID || ost != '0;
`endif
  always_ff @(posedge PI_CLK or posedge PI_RST)
    if (PI_RST) begin
      data_reg <= '0;
      addr_lo <= '0;
      addr_phase <= 1'b0;
      PI_D_OUT <= '0;
      ost <= '0;
      BERR_SEEN <= 1'b0;
      OVERFLOW <= 1'b0;
      TXN_IN_PROGRESS <= 1'b0;
    end else begin
      if (wr_edge && PI_A == REG_DATA) data_reg <= PI_D_IN;
      if (wr_edge && PI_A == REG_ADDR_LO) addr_lo <= PI_D_IN;
      addr_phase <= (wr_edge && PI_A == REG_ADDR_LO) || (addr_phase && !enq);
      if (dec && sh_rw) PI_D_OUT <= RSP_DATA;
      ost <= ost + (AW+1)'(xfer) - (AW+1)'(dec);
      BERR_SEEN <= (dec && RSP_BERR) || (BERR_SEEN && !clr);
      OVERFLOW <= (enq && cmd_full && !xfer) || (OVERFLOW && !clr);
      TXN_IN_PROGRESS <= busy;
    end
endmodule

// File: tb/tb_pi_txn_queue.sv
// tb_pi_txn_queue: randomized transaction-level checks of pi_txn_queue against a queue-based model.
module tb_pi_txn_queue;
  localparam int DEPTH = 4;
  logic PI_CLK = 0, PI_RST = 1, PI_RD = 0, PI_WR = 0, CMD_READY = 0, RSP_VALID = 0, RSP_BERR = 0;
  logic [1:0] PI_A = 0;
  logic [15:0] PI_D_IN = 0, RSP_DATA = 0;
  logic [15:0] PI_D_OUT, CMD_DATA;
  logic [23:0] CMD_ADDR;
  logic [2:0] CMD_FC;
  logic PI_D_OE, TXN_IN_PROGRESS, CMD_VALID, CMD_RW, CMD_UDS_n, CMD_LDS_n, BERR_SEEN, OVERFLOW;
  int checks = 0, errors = 0;
  typedef struct {int addr; int data; int rw; int uds; int lds; int fc;} exp_t;
  exp_t exp_q[$];
  int out_rw[$];
  int exp_rd = 0, exp_berr = 0, exp_ovf = 0, cur_lo = 0, cur_data = 0;

  always #5 PI_CLK = ~PI_CLK;

  pi_txn_queue #(.DEPTH(DEPTH)) dut (
    .PI_CLK(PI_CLK), .PI_RST(PI_RST), .PI_A(PI_A), .PI_RD(PI_RD), .PI_WR(PI_WR), .PI_D_IN(PI_D_IN),
    .PI_D_OUT(PI_D_OUT), .PI_D_OE(PI_D_OE), .TXN_IN_PROGRESS(TXN_IN_PROGRESS), .CMD_VALID(CMD_VALID),
    .CMD_READY(CMD_READY), .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA), .CMD_RW(CMD_RW),
    .CMD_UDS_n(CMD_UDS_n), .CMD_LDS_n(CMD_LDS_n), .CMD_FC(CMD_FC), .RSP_VALID(RSP_VALID),
    .RSP_DATA(RSP_DATA), .RSP_BERR(RSP_BERR), .BERR_SEEN(BERR_SEEN), .OVERFLOW(OVERFLOW)
  );

  function automatic exp_t mk(input int lo, input int hi, input int dat);
    exp_t e;
    int byte_acc;
    byte_acc = (hi / 256) % 2;
    e.addr = (hi % 256) * 65536 + lo;
    e.data = dat;
    e.rw = (hi / 512) % 2;
    e.fc = hi / 8192;
    e.uds = byte_acc ? lo % 2 : 0;
    e.lds = byte_acc ? 1 - lo % 2 : 0;
    return e;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge PI_CLK);
    #1;
  endtask

  task automatic pi_write(input int a, input int d);
    PI_A = 2'(a); PI_D_IN = 16'(d); PI_WR = 1;
    tick(4);
    PI_WR = 0;
    tick(3);
    if (a == 0) cur_data = d;
    else if (a == 1) cur_lo = d;
    else if (a == 2) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(mk(cur_lo, d, cur_data));
      else exp_ovf = 1;
    end
  endtask

  task automatic status_read();
    PI_A = 2'd3; PI_RD = 1;
    tick(4);
    PI_RD = 0;
    tick(3);
    exp_berr = 0; exp_ovf = 0;
  endtask

  task automatic respond(input int d, input int b);
    RSP_VALID = 1; RSP_DATA = 16'(d); RSP_BERR = b[0];
    tick();
    RSP_VALID = 0; RSP_BERR = 0;
    if (out_rw.size() > 0) begin
      if (out_rw.pop_front() != 0) exp_rd = d;
      if (b != 0) exp_berr = 1;
    end
  endtask

  task automatic drain_one();
    exp_t e;
    int n = 0;
    while (CMD_VALID !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (CMD_VALID !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL drain_valid got valid=%b expected queued=%0d", CMD_VALID, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      checks++;
      if ({CMD_ADDR, CMD_DATA, CMD_RW, CMD_UDS_n, CMD_LDS_n, CMD_FC} !==
          {24'(e.addr), 16'(e.data), 1'(e.rw), 1'(e.uds), 1'(e.lds), 3'(e.fc)}) begin
        errors++;
        $display("FAIL cmd_fields got addr=%h data=%h rw=%b uds=%b lds=%b fc=%0d exp addr=%h data=%h rw=%0d uds=%0d lds=%0d fc=%0d",
                 CMD_ADDR, CMD_DATA, CMD_RW, CMD_UDS_n, CMD_LDS_n, CMD_FC, e.addr[23:0], e.data[15:0], e.rw, e.uds, e.lds, e.fc);
      end
      CMD_READY = 1;
      tick();
      CMD_READY = 0;
      out_rw.push_back(e.rw);
    end
  endtask

  task automatic test_reset();
    PI_RST = 1;
    tick(2);
    PI_RST = 0;
    tick();
    checks++;
    if ({CMD_VALID, CMD_UDS_n, CMD_LDS_n, CMD_RW, CMD_FC} !== 7'b0111111) begin
      errors++; $display("FAIL reset_cmd got v/uds/lds/rw/fc=%b exp 0111111", {CMD_VALID, CMD_UDS_n, CMD_LDS_n, CMD_RW, CMD_FC});
    end
    checks++;
    if ({CMD_ADDR, CMD_DATA, PI_D_OUT} !== 56'h0) begin
      errors++; $display("FAIL reset_data got addr=%h data=%h dout=%h exp 0", CMD_ADDR, CMD_DATA, PI_D_OUT);
    end
    checks++;
    if ({TXN_IN_PROGRESS, BERR_SEEN, OVERFLOW, PI_D_OE} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 0000", {TXN_IN_PROGRESS, BERR_SEEN, OVERFLOW, PI_D_OE});
    end
  endtask

  task automatic test_write_seq();
    pi_write(0, 16'hBEEF);
    pi_write(1, 16'h1235);
    checks++;
    if (TXN_IN_PROGRESS !== 1'b1) begin errors++; $display("FAIL addr_phase_busy got %b exp 1", TXN_IN_PROGRESS); end
    PI_A = 2'd2; PI_D_IN = 16'h2112; PI_WR = 1;
    tick(2);
    checks++;
    if (CMD_VALID !== 1'b0) begin errors++; $display("FAIL valid_early got %b exp 0", CMD_VALID); end
    tick(1);
    checks++;
    if (CMD_VALID !== 1'b1) begin errors++; $display("FAIL valid_latency got %b exp 1", CMD_VALID); end
    PI_WR = 0;
    exp_q.push_back(mk(cur_lo, 16'h2112, cur_data));
    tick(3);
    checks++;
    if ({CMD_ADDR, CMD_UDS_n, CMD_LDS_n, CMD_FC} !== {24'h121235, 1'b1, 1'b0, 3'd1}) begin
      errors++; $display("FAIL write_seq got addr=%h uds=%b lds=%b fc=%0d exp 121235 1 0 1", CMD_ADDR, CMD_UDS_n, CMD_LDS_n, CMD_FC);
    end
    drain_one();
    respond($urandom_range(0, 65535), 0);
    tick(2);
    checks++;
    if (TXN_IN_PROGRESS !== 1'b0) begin errors++; $display("FAIL write_done_busy got %b exp 0", TXN_IN_PROGRESS); end
  endtask

  task automatic test_word_read();
    int hi;
    pi_write(1, $urandom_range(0, 65535));
    hi = ($urandom_range(0, 65535) & 16'hE0FF) | 16'h0200;
    pi_write(2, hi);
    drain_one();
    respond(16'hA5A5, 0);
    checks++;
    if (TXN_IN_PROGRESS !== 1'b1) begin errors++; $display("FAIL read_busy_hold got %b exp 1", TXN_IN_PROGRESS); end
    tick();
    checks++;
    if (TXN_IN_PROGRESS !== 1'b0) begin errors++; $display("FAIL read_busy_fall got %b exp 0", TXN_IN_PROGRESS); end
    PI_A = 2'd0; PI_RD = 1;
    #1;
    checks++;
    if ({PI_D_OE, PI_D_OUT} !== {1'b1, 16'(exp_rd)}) begin
      errors++; $display("FAIL read_data got oe=%b dout=%h exp oe=1 dout=%h", PI_D_OE, PI_D_OUT, exp_rd[15:0]);
    end
    PI_RD = 0;
    tick(4);
  endtask

  task automatic test_random();
    int b;
    for (int i = 0; i < 12; i++) begin
      pi_write(0, $urandom_range(0, 65535));
      pi_write(1, $urandom_range(0, 65535));
      pi_write(2, $urandom_range(0, 65535));
      drain_one();
      b = ($urandom_range(0, 3) == 0) ? 1 : 0;
      respond($urandom_range(0, 65535), b);
      tick();
      checks++;
      if ({PI_D_OUT, BERR_SEEN, TXN_IN_PROGRESS} !== {16'(exp_rd), 1'(exp_berr), 1'b0}) begin
        errors++; $display("FAIL random_rsp[%0d] got dout=%h berr=%b busy=%b exp dout=%h berr=%0d busy=0",
                           i, PI_D_OUT, BERR_SEEN, TXN_IN_PROGRESS, exp_rd[15:0], exp_berr);
      end
    end
    status_read();
    checks++;
    if (BERR_SEEN !== 1'b0) begin errors++; $display("FAIL random_clear got %b exp 0", BERR_SEEN); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH + 1; i++) pi_write(2, $urandom_range(0, 65535));
    checks++;
    if ({OVERFLOW, TXN_IN_PROGRESS} !== {1'(exp_ovf), 1'b1}) begin
      errors++; $display("FAIL overflow_set got ovf=%b busy=%b exp ovf=%0d busy=1", OVERFLOW, TXN_IN_PROGRESS, exp_ovf);
    end
    for (int i = 0; i < DEPTH; i++) drain_one();
    tick(2);
    checks++;
    if (CMD_VALID !== 1'b0) begin errors++; $display("FAIL overflow_drained got %b exp 0", CMD_VALID); end
    for (int i = 0; i < DEPTH; i++) respond($urandom_range(0, 65535), 0);
    checks++;
    if (PI_D_OUT !== 16'(exp_rd)) begin errors++; $display("FAIL overflow_rd got %h exp %h", PI_D_OUT, exp_rd[15:0]); end
    status_read();
    checks++;
    if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL overflow_clear got %b exp 0", OVERFLOW); end
  endtask

  task automatic test_full_dequeue();
    exp_t e;
    int h;
    for (int i = 0; i < DEPTH; i++) pi_write(2, $urandom_range(0, 65535));
    h = $urandom_range(0, 65535);
    PI_A = 2'd2; PI_D_IN = 16'(h); PI_WR = 1;
    tick(2);
    e = exp_q.pop_front();
    checks++;
    if ({CMD_VALID, CMD_ADDR, CMD_RW} !== {1'b1, 24'(e.addr), 1'(e.rw)}) begin
      errors++; $display("FAIL full_head got v=%b addr=%h rw=%b exp v=1 addr=%h rw=%0d", CMD_VALID, CMD_ADDR, CMD_RW, e.addr[23:0], e.rw);
    end
    CMD_READY = 1;
    tick();
    CMD_READY = 0;
    out_rw.push_back(e.rw);
    exp_q.push_back(mk(cur_lo, h, cur_data));
    PI_WR = 0;
    tick(3);
    checks++;
    if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL full_dequeue_ovf got %b exp 0", OVERFLOW); end
    respond($urandom_range(0, 65535), 0);
    for (int i = 0; i < DEPTH; i++) drain_one();
    tick(2);
    checks++;
    if (CMD_VALID !== 1'b0) begin errors++; $display("FAIL full_dequeue_drained got %b exp 0", CMD_VALID); end
    for (int i = 0; i < DEPTH; i++) respond($urandom_range(0, 65535), 0);
    checks++;
    if (PI_D_OUT !== 16'(exp_rd)) begin errors++; $display("FAIL full_dequeue_rd got %h exp %h", PI_D_OUT, exp_rd[15:0]); end
  endtask

  task automatic test_berr();
    pi_write(2, $urandom_range(0, 65535) & 16'hFDFF);
    drain_one();
    respond($urandom_range(0, 65535), 1);
    checks++;
    if ({BERR_SEEN, PI_D_OUT} !== {1'b1, 16'(exp_rd)}) begin
      errors++; $display("FAIL berr_set got berr=%b dout=%h exp berr=1 dout=%h", BERR_SEEN, PI_D_OUT, exp_rd[15:0]);
    end
    status_read();
    checks++;
    if (BERR_SEEN !== 1'b0) begin errors++; $display("FAIL berr_clear got %b exp 0", BERR_SEEN); end
    pi_write(2, $urandom_range(0, 65535) & 16'hFDFF);
    drain_one();
    PI_A = 2'd3; PI_RD = 1;
    tick(2);
    RSP_VALID = 1; RSP_BERR = 1; RSP_DATA = 16'h0;
    tick();
    RSP_VALID = 0; RSP_BERR = 0;
    void'(out_rw.pop_front());
    PI_RD = 0;
    tick(3);
    checks++;
    if (BERR_SEEN !== 1'b1) begin errors++; $display("FAIL berr_set_beats_clear got %b exp 1", BERR_SEEN); end
    status_read();
    checks++;
    if (BERR_SEEN !== 1'b0) begin errors++; $display("FAIL berr_clear2 got %b exp 0", BERR_SEEN); end
  endtask

  task automatic test_reset_mid();
    pi_write(2, $urandom_range(0, 65535));
    drain_one();
    respond($urandom_range(0, 65535), 1);
    pi_write(2, $urandom_range(0, 65535));
    drain_one();
    pi_write(2, $urandom_range(0, 65535));
    drain_one();
    pi_write(2, $urandom_range(0, 65535));
    checks++;
    if ({CMD_VALID, BERR_SEEN, TXN_IN_PROGRESS} !== 3'b111) begin
      errors++; $display("FAIL pre_reset got v/berr/busy=%b exp 111", {CMD_VALID, BERR_SEEN, TXN_IN_PROGRESS});
    end
    @(posedge PI_CLK);
    #3;
    PI_RST = 1;
    #1;
    checks++;
    if ({CMD_VALID, BERR_SEEN, OVERFLOW, TXN_IN_PROGRESS, CMD_FC} !== 7'b0000111) begin
      errors++; $display("FAIL async_reset got %b exp 0000111", {CMD_VALID, BERR_SEEN, OVERFLOW, TXN_IN_PROGRESS, CMD_FC});
    end
    tick();
    PI_RST = 0;
    exp_q.delete(); out_rw.delete();
    exp_rd = 0; exp_berr = 0; exp_ovf = 0; cur_lo = 0; cur_data = 0;
    tick();
    respond(16'hFFFF, 1);
    tick(2);
    checks++;
    if ({CMD_VALID, BERR_SEEN, TXN_IN_PROGRESS, PI_D_OUT} !== 19'h0) begin
      errors++; $display("FAIL stray_rsp got v=%b berr=%b busy=%b dout=%h exp all 0", CMD_VALID, BERR_SEEN, TXN_IN_PROGRESS, PI_D_OUT);
    end
  endtask

  initial begin
    test_reset();
    test_write_seq();
    test_word_read();
    test_random();
    test_overflow();
    test_full_dequeue();
    test_berr();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
